// File: rtl/ram_sync_clr.sv
// Single-port synchronous RAM with a hardware clear sweep.
// After reset, or on a clr request, every word is written with CLEAR_VALUE,
// one word per cycle. Accesses that arrive during a sweep, or together with
// a clr request, are dropped and flagged on rej.
module ram_sync_clr #(
   parameter int unsigned           DATA_WIDTH  = 4,
   parameter int unsigned           ADDR_WIDTH  = 12,
   parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  cs,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] address,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic                  clr,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic                  rvalid,
   output logic                  busy,
   output logic                  rej
);

   localparam int unsigned RAM_DEPTH = 1 << ADDR_WIDTH;

   typedef enum logic {
      CLEAR,
      IDLE
   } state_t;

   state_t                  state;
   state_t                  state_next;
   logic [ADDR_WIDTH-1:0]   ccnt;
   logic [DATA_WIDTH-1:0]   mem [RAM_DEPTH];

   logic                    wr_en;
   logic [ADDR_WIDTH-1:0]   wr_addr;
   logic [DATA_WIDTH-1:0]   wr_data;
   logic                    rd_en;

   // State register; reset lands in CLEAR so a sweep follows every reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= CLEAR;
      end else begin
         state <= state_next;
      end
   end

   // Next state: sweep ends on the edge writing the last word; clr starts one from IDLE
   always_comb begin
      state_next = state;
      case (state)
         CLEAR:   if (ccnt == '1) state_next = IDLE;
         IDLE:    if (clr)        state_next = CLEAR;
         default: state_next = CLEAR;
      endcase
   end

   // State-decoded outputs
   always_comb begin
      busy = (state == CLEAR);
   end

   // Memory port steering: sweep owns the write port in CLEAR, accesses only in IDLE without clr
   always_comb begin
      wr_en   = 1'b0;
      wr_addr = '0;
      wr_data = '0;
      rd_en   = 1'b0;
      if (state == CLEAR) begin
         wr_en   = 1'b1;
         wr_addr = ccnt;
         wr_data = CLEAR_VALUE;
      end else if (cs && !clr) begin
         if (we) begin
            wr_en   = 1'b1;
            wr_addr = address;
            wr_data = wdata;
         end else begin
            rd_en   = 1'b1;
         end
      end
   end

   // Clear counter, registered read data and the one-cycle status pulses
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ccnt   <= '0;
         rdata  <= '0;
         rvalid <= 1'b0;
         rej    <= 1'b0;
      end else begin
         rvalid <= 1'b0;
         rej    <= cs && ((state == CLEAR) || clr);
         case (state)
            CLEAR:   ccnt <= ccnt + 1'b1;
            IDLE:    if (clr) ccnt <= '0;
            default: ccnt <= '0;
         endcase
         if (rd_en) begin
            rdata  <= mem[address];
            rvalid <= 1'b1;
         end
      end
   end

   // Storage array; deliberately not reset, only the sweep initialises it
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

endmodule
